// File: rtl/hack_ram_loader_if.sv
// hack_ram_loader_if: byte-stream input, CPU RAM port and RAM-side port of the
// boot loader, grouped so the loader and its environment share one bundle.
interface hack_ram_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cpu_write_en;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_in_data;
    logic        ram_write_en;
    logic [15:0] ram_addr;
    logic [15:0] ram_in_data;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    // Loader side.
    modport slave (
        input  rx_valid, rx_data, cpu_write_en, cpu_addr, cpu_in_data,
        output ram_write_en, ram_addr, ram_in_data, cpu_rst_n, busy, done, error
    );

    // Environment side: UART receiver, CPU and RAM.
    modport master (
        output rx_valid, rx_data, cpu_write_en, cpu_addr, cpu_in_data,
        input  ram_write_en, ram_addr, ram_in_data, cpu_rst_n, busy, done, error
    );
endinterface

// File: rtl/hack_ram_loader.sv
// hack_ram_loader: boot-time loader in front of the Hack data RAM.
// Frame: count_hi count_lo (N), then N big-endian words written to addresses
// 0..N-1 while the CPU is held in reset. On success the RAM port is handed to
// the CPU and cpu_rst_n is released; failures are sticky until rst_n.
// Optional feature: define HACK_LOADER_CHECKSUM_EN to require a trailing
// big-endian 16-bit checksum (sum mod 2^16 of the data words) before DONE.
module hack_ram_loader #(
    parameter int DEPTH          = 16384,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    hack_ram_loader_if.slave bus
);
    // Idle counter holds 0..TIMEOUT_CYCLES-1; the timeout fires on the cycle
    // that would reach TIMEOUT_CYCLES, so error shows TIMEOUT_CYCLES+1 cycles
    // after the last accepted byte.
    localparam int             TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [16:0]    DEPTH_W = 17'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM_HI,
        S_CSUM_LO,
        S_FINISH,
        S_DONE,
        S_ERROR
    } state_t;

`ifdef HACK_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = S_CSUM_HI;
`else
    localparam state_t AFTER_DATA = S_FINISH;
`endif

    state_t        state_q, state_d;
    logic [7:0]    cnt_hi_q, cnt_hi_d;
    logic [15:0]   n_q, n_d;
    logic [7:0]    byte_hi_q, byte_hi_d;
    logic [14:0]   word_cnt_q, word_cnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          wr_en_q, wr_en_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
`ifdef HACK_LOADER_CHECKSUM_EN
    logic [15:0]   csum_q, csum_d;
`endif

    logic [15:0]   word;
    logic [15:0]   count_lo;
    logic          last_word;
    logic          timing;
    logic          timed_out;
    logic          done_w;

    // Next-state, byte assembly, write strobe and idle-timeout logic.
    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        n_d        = n_q;
        byte_hi_d  = byte_hi_q;
        word_cnt_d = word_cnt_q;
        idle_d     = idle_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef HACK_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        word      = {byte_hi_q, bus.rx_data};
        count_lo  = {cnt_hi_q, bus.rx_data};
        last_word = (({1'b0, word_cnt_q} + 16'd1) == n_q);
        timing    = (state_q inside {S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO});
        timed_out = (TIMEOUT_CYCLES > 0) && timing && !bus.rx_valid && (idle_q == TO_LAST);

        // Counter only runs mid-transfer; any byte restarts the window.
        if (bus.rx_valid || !timing) begin
            idle_d = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
            idle_d = idle_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    cnt_hi_d = bus.rx_data;
                    state_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (bus.rx_valid) begin
                    n_d        = count_lo;
                    word_cnt_d = '0;
`ifdef HACK_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    if ({1'b0, count_lo} > DEPTH_W) begin
                        state_d = S_ERROR;
                    end else if (count_lo == 16'd0) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (bus.rx_valid) begin
                    byte_hi_d = bus.rx_data;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (bus.rx_valid) begin
                    wr_en_d    = 1'b1;
                    addr_d     = {1'b0, word_cnt_q};
                    wdata_d    = word;
                    word_cnt_d = word_cnt_q + 15'd1;
`ifdef HACK_LOADER_CHECKSUM_EN
                    csum_d     = csum_q + word;
`endif
                    state_d    = last_word ? AFTER_DATA : S_DATA_HI;
                end
            end
`ifdef HACK_LOADER_CHECKSUM_EN
            S_CSUM_HI: begin
                if (bus.rx_valid) begin
                    byte_hi_d = bus.rx_data;
                    state_d   = S_CSUM_LO;
                end
            end
            S_CSUM_LO: begin
                if (bus.rx_valid) begin
                    state_d = (word == csum_q) ? S_FINISH : S_ERROR;
                end
            end
`endif
            S_FINISH: state_d = S_DONE;
            S_DONE:   state_d = S_DONE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase

        // timed_out implies no byte this cycle, so nothing above is lost.
        if (timed_out) begin
            state_d = S_ERROR;
        end
    end

    // Control state and RAM-side output registers, cleared by rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idle_q  <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Frame datapath registers; always loaded before use within a frame.
    always_ff @(posedge clk) begin
        cnt_hi_q   <= cnt_hi_d;
        n_q        <= n_d;
        byte_hi_q  <= byte_hi_d;
        word_cnt_q <= word_cnt_d;
`ifdef HACK_LOADER_CHECKSUM_EN
        csum_q     <= csum_d;
`endif
    end

    // Status flags decoded from the registered state; the CPU owns the RAM
    // port only once DONE is registered.
    assign done_w           = (state_q == S_DONE);
    assign bus.done         = done_w;
    assign bus.error        = (state_q == S_ERROR);
    assign bus.busy         = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign bus.cpu_rst_n    = done_w;
    assign bus.ram_write_en = done_w ? bus.cpu_write_en : wr_en_q;
    assign bus.ram_addr     = done_w ? bus.cpu_addr     : addr_q;
    assign bus.ram_in_data  = done_w ? bus.cpu_in_data  : wdata_q;
endmodule

// File: tb/tb_hack_ram_loader.sv
// tb_hack_ram_loader: table-driven frames, hand-timed corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_hack_ram_loader;
    localparam int DEPTH = 16384;
    localparam int TO    = 100;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];

    typedef struct {
        logic [63:0] bytes;   // byte i at [63-8*i -: 8]
        int          len;
        bit          exp_done;
        bit          exp_err;
        int          exp_nwr;
        logic [15:0] exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hack_ram_loader_if bus ();

    hack_ram_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;
    wq_t got_a;
    wq_t got_d;

    // Record every loader write strobe seen while the loader owns the RAM.
    always @(negedge clk) begin
        if (mon_en && bus.ram_write_en && !bus.done) begin
            got_a.push_back(bus.ram_addr);
            got_d.push_back(bus.ram_in_data);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 8'h00;
        bus.cpu_write_en = 1'b0;
        bus.cpu_addr     = 16'h0;
        bus.cpu_in_data  = 16'h0;
        @(negedge clk);
        check("reset_ctl", {bus.ram_write_en, bus.cpu_rst_n, bus.busy, bus.done, bus.error}, 0);
        check("reset_bus", {bus.ram_addr, bus.ram_in_data}, 0);
        rst_n = 1'b1;
    endtask

    // Byte is consumed at the posedge following the call; returns at the next
    // negedge, where outputs show cycle T+1.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic drive_frame(input bq_t b, input int maxgap);
        do_reset();
        got_a.delete();
        got_d.delete();
        mon_en = 1'b1;
        foreach (b[i]) begin
            send_byte(b[i]);
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
    endtask

    // Frame-level reference: which words get written and how the load ends.
    function automatic void model(input bq_t b, output wq_t words, output bit dn, output bit er);
        int          n;
        logic [15:0] sum;
        words.delete();
        dn  = 1'b0;
        er  = 1'b0;
        sum = 16'h0;
        if (b.size() < 2) return;
        n = {b[0], b[1]};
        if (n > DEPTH) begin
            er = 1'b1;
            return;
        end
        for (int k = 0; k < n && (3 + 2 * k) < b.size(); k++) begin
            words.push_back({b[2 + 2 * k], b[3 + 2 * k]});
            sum = sum + {b[2 + 2 * k], b[3 + 2 * k]};
        end
        if (words.size() < n) return;
`ifdef HACK_LOADER_CHECKSUM_EN
        if (b.size() < 4 + 2 * n) return;
        if ({b[2 + 2 * n], b[3 + 2 * n]} == sum) dn = 1'b1;
        else er = 1'b1;
`else
        dn = 1'b1;
`endif
    endfunction

    task automatic check_outcome(input string nm, input bit dn, input bit er, input int len);
        check({nm, "/done"}, bus.done, dn);
        check({nm, "/error"}, bus.error, er);
        check({nm, "/cpu_rst_n"}, bus.cpu_rst_n, dn);
        check({nm, "/busy"}, bus.busy, (!dn && !er && len > 0));
    endtask

    vec_t        tv[6];
    bq_t         b;
    wq_t         exp_w;
    bit          m_dn, m_er;
    int          n, c, mn;
    logic [15:0] sum, w;

    initial begin
`ifdef HACK_LOADER_CHECKSUM_EN
        tv[0] = '{64'h0002_0001_0005_0006, 8, 1'b1, 1'b0, 2, 16'h0005};
        tv[1] = '{64'h0000_0000_0000_0000, 4, 1'b1, 1'b0, 0, 16'h0000};
        tv[2] = '{64'h4001_0011_0000_0000, 4, 1'b0, 1'b1, 0, 16'h0000};
        tv[3] = '{64'h4000_0000_0000_0000, 2, 1'b0, 1'b0, 0, 16'h0000};
        tv[4] = '{64'h0001_1234_1234_0000, 6, 1'b1, 1'b0, 1, 16'h1234};
        tv[5] = '{64'h0001_1234_1235_0000, 6, 1'b0, 1'b1, 1, 16'h1234};
`else
        tv[0] = '{64'h0002_0001_0005_0000, 6, 1'b1, 1'b0, 2, 16'h0005};
        tv[1] = '{64'h0000_0000_0000_0000, 2, 1'b1, 1'b0, 0, 16'h0000};
        tv[2] = '{64'h4001_0011_0000_0000, 4, 1'b0, 1'b1, 0, 16'h0000};
        tv[3] = '{64'h4000_0000_0000_0000, 2, 1'b0, 1'b0, 0, 16'h0000};
        tv[4] = '{64'h0001_ABCD_FFFF_0000, 6, 1'b1, 1'b0, 1, 16'hABCD};
        tv[5] = '{64'h0003_0000_0000_0000, 3, 1'b0, 1'b0, 0, 16'h0000};
`endif

        // Table-driven frames, bytes back to back.
        for (int t = 0; t < 6; t++) begin
            b.delete();
            for (int i = 0; i < tv[t].len; i++) b.push_back(tv[t].bytes[63 - 8 * i -: 8]);
            drive_frame(b, 0);
            check($sformatf("tv%0d/nwr", t), got_a.size(), tv[t].exp_nwr);
            foreach (got_a[i]) check($sformatf("tv%0d/addr%0d", t, i), got_a[i], i);
            if (got_d.size() > 0) check($sformatf("tv%0d/last", t), got_d[$], tv[t].exp_last);
            check_outcome($sformatf("tv%0d", t), tv[t].exp_done, tv[t].exp_err, tv[t].len);
        end

        // Strobe and done latency relative to the final accepted byte.
        do_reset();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        check("A/w0_we", bus.ram_write_en, 1);
        check("A/w0_bus", {bus.ram_addr, bus.ram_in_data}, {16'h0000, 16'h0001});
        send_byte(8'h00);
        check("A/pulse_one_cycle", bus.ram_write_en, 0);
        send_byte(8'h05);
        check("A/w1_we", bus.ram_write_en, 1);
        check("A/w1_bus", {bus.ram_addr, bus.ram_in_data}, {16'h0001, 16'h0005});
`ifdef HACK_LOADER_CHECKSUM_EN
        send_byte(8'h00); send_byte(8'h06);
        check("A/csum_no_we", bus.ram_write_en, 0);
`endif
        check("A/t1_done", {bus.done, bus.cpu_rst_n, bus.busy}, 3'b001);
        @(negedge clk);
        check("A/t2_done", {bus.done, bus.cpu_rst_n, bus.busy, bus.ram_write_en}, 4'b1100);

        // Empty frame: done two cycles after the count low byte.
        do_reset();
        got_a.delete(); got_d.delete(); mon_en = 1'b1;
        send_byte(8'h00); send_byte(8'h00);
`ifdef HACK_LOADER_CHECKSUM_EN
        send_byte(8'h00); send_byte(8'h00);
`endif
        check("B/t1_done", bus.done, 0);
        @(negedge clk);
        check("B/t2_done", {bus.done, bus.cpu_rst_n}, 2'b11);
        mon_en = 1'b0;
        check("B/no_strobe", got_a.size(), 0);

        // Oversize count: error next cycle, later bytes ignored.
        do_reset();
        got_a.delete(); got_d.delete(); mon_en = 1'b1;
        send_byte(8'h40); send_byte(8'h01);
        check("C/t1_error", {bus.error, bus.busy, bus.cpu_rst_n, bus.done}, 4'b1000);
        send_byte(8'h00); send_byte(8'h05); send_byte(8'h00); send_byte(8'h07);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("C/no_strobe", got_a.size(), 0);
        check("C/sticky", {bus.error, bus.cpu_rst_n}, 2'b10);

        // Timeout: a byte on the last allowed cycle restarts the window.
        do_reset();
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h11);
        check("D/late_byte_ok", {bus.error, bus.busy}, 2'b01);
        check("D/late_byte_we", {bus.ram_write_en, bus.ram_addr, bus.ram_in_data}, {1'b1, 16'h0000, 16'h0011});
        c = 1;
        while (!bus.error && c < 3 * TO) begin
            @(negedge clk);
            c++;
        end
        check("D/timeout_cycles", c, TO + 1);
        check("D/after_timeout", {bus.error, bus.busy, bus.cpu_rst_n, bus.ram_write_en}, 4'b1000);

        // Ownership mux: CPU writes invisible until done, mirrored after.
        do_reset();
        bus.cpu_write_en = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_in_data = 16'hBEEF;
        send_byte(8'h00); send_byte(8'h01);
        check("E/cpu_hidden", {bus.ram_write_en, bus.ram_addr, bus.ram_in_data}, 33'h0);
        send_byte(8'h12); send_byte(8'h34);
        check("E/loader_write", {bus.ram_write_en, bus.ram_addr, bus.ram_in_data}, {1'b1, 16'h0000, 16'h1234});
`ifdef HACK_LOADER_CHECKSUM_EN
        send_byte(8'h12); send_byte(8'h34);
`endif
        @(negedge clk);
        check("E/cpu_owns", {bus.ram_write_en, bus.ram_addr, bus.ram_in_data}, {1'b1, 16'h0010, 16'hBEEF});
        bus.cpu_write_en = 1'b0; bus.cpu_addr = 16'h1234; bus.cpu_in_data = 16'h5678;
        #1;
        check("E/same_cycle", {bus.ram_write_en, bus.ram_addr, bus.ram_in_data}, {1'b0, 16'h1234, 16'h5678});

        // Randomized frames against the reference model.
        for (int r = 0; r < 24; r++) begin
            b.delete();
            sum = 16'h0;
            if ($urandom_range(9, 0) == 0) n = $urandom_range(65535, DEPTH + 1);
            else n = $urandom_range(6, 0);
            b.push_back(n[15:8]);
            b.push_back(n[7:0]);
            if (n <= DEPTH) begin
                for (int k = 0; k < n; k++) begin
                    w = 16'($urandom);
                    sum = sum + w;
                    b.push_back(w[15:8]);
                    b.push_back(w[7:0]);
                end
`ifdef HACK_LOADER_CHECKSUM_EN
                if ($urandom_range(3, 0) == 0) sum = sum ^ 16'($urandom_range(65535, 1));
                b.push_back(sum[15:8]);
                b.push_back(sum[7:0]);
`endif
            end
            repeat ($urandom_range(2, 0)) b.push_back(8'($urandom));
            drive_frame(b, 2);
            model(b, exp_w, m_dn, m_er);
            check($sformatf("rnd%0d/nwr", r), got_a.size(), exp_w.size());
            mn = (got_a.size() < exp_w.size()) ? got_a.size() : exp_w.size();
            for (int i = 0; i < mn; i++) begin
                check($sformatf("rnd%0d/addr%0d", r, i), got_a[i], i);
                check($sformatf("rnd%0d/data%0d", r, i), got_d[i], exp_w[i]);
            end
            check_outcome($sformatf("rnd%0d", r), m_dn, m_er, b.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
